// File: rtl/data_send_pkg.sv
// Shared widths and FSM encoding for the multi-lane serial send buffer.
package data_send_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned LANES       = 4;
  localparam int unsigned BUFFER_SIZE = 4096;
  localparam int unsigned WORDS       = BUFFER_SIZE / WORD_W;
  localparam int unsigned ADDR_W      = $clog2(WORDS);
  localparam int unsigned LEN_W       = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned SEL_W       = $clog2(LANES);
  localparam int unsigned BIT_W       = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/data_send_lane_ram.sv
// One lane of word storage: single write port, registered read (old data on same-address write).
module data_send_lane_ram
  import data_send_pkg::*;
#(
  parameter int unsigned DEPTH = WORDS,
  parameter int unsigned AW    = ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/data_send_buffer.sv
// Multi-lane serial send buffer: streams stored words LSB first, one bit per lane per cycle.
// Optional repeat mode is enabled by defining DATA_SEND_BUFFER_LOOP_EN.
module data_send_buffer #(
  parameter int unsigned BUFFER_SIZE = data_send_pkg::BUFFER_SIZE,
  parameter int unsigned LANES       = data_send_pkg::LANES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [data_send_pkg::ADDR_W-1:0] wr_addr,
  input  logic [data_send_pkg::SEL_W-1:0]  wr_sel,
  input  logic [data_send_pkg::WORD_W-1:0] wr_data,
  input  logic                             wr_en,
  input  logic [data_send_pkg::LEN_W-1:0]  length,
  input  logic                             loop,
  input  logic                             start,
  input  logic                             stop,
  output logic [LANES-1:0]                 tx_data,
  output logic                             tx_valid,
  output logic                             busy,
  output logic                             done
);
  import data_send_pkg::*;

  localparam int unsigned WORDS_P = BUFFER_SIZE / WORD_W;

  state_e            state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic              loop_q;
  logic              loop_en_c;
  logic [LEN_W-1:0]  nxt_c;
  logic [LEN_W-1:0]  len_in_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [LANES-1:0]  cur_bits_c;
  logic [WORD_W-1:0] rd_word [LANES];

`ifdef DATA_SEND_BUFFER_LOOP_EN
  assign loop_en_c = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en_c   = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    data_send_lane_ram #(
      .DEPTH (WORDS_P),
      .AW    (ADDR_W)
    ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en && (wr_sel == SEL_W'(i))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr_c),
      .rd_data (rd_word[i])
    );
    assign cur_bits_c[i] = rd_word[i][cnt[BIT_W-1:0]];
  end

  // cnt is the bit loaded at the next edge; the read runs one bit ahead so the
  // word holding that bit is always already in the RAM output register.
  // Without looping cnt runs up to len_q, which marks the pass as drained.
  always_comb begin
    nxt_c     = cnt + LEN_W'(1);
    rd_addr_c = '0;
    if (loop_q && (cnt + LEN_W'(1) == len_q)) begin
      nxt_c = '0;
    end
    if (state != IDLE) begin
      rd_addr_c = ADDR_W'(nxt_c >> BIT_W);
    end
    len_in_c = (length > LEN_W'(BUFFER_SIZE)) ? LEN_W'(BUFFER_SIZE) : length;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      case (state)
        IDLE: begin
          if (start && !stop && (length != '0)) begin
            len_q  <= len_in_c;
            loop_q <= loop_en_c;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= PRIME;
          end
        end
        PRIME, SEND: begin
          if (stop || (cnt == len_q)) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            tx_valid <= 1'b1;
            tx_data  <= cur_bits_c;
            cnt      <= nxt_c;
            state    <= SEND;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_send_buffer.sv
// Self-checking bench for data_send_buffer using a bit-stream scoreboard against a memory model.
module tb_data_send_buffer;
  import data_send_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] wr_addr;
  logic [SEL_W-1:0]  wr_sel;
  logic [WORD_W-1:0] wr_data;
  logic              wr_en;
  logic [LEN_W-1:0]  length;
  logic              loop;
  logic              start;
  logic              stop;
  logic [LANES-1:0]  tx_data;
  logic              tx_valid;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  data_send_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .wr_addr  (wr_addr),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .length   (length),
    .loop     (loop),
    .start    (start),
    .stop     (stop),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy),
    .done     (done)
  );

  logic [WORD_W-1:0] model [LANES][WORDS];
  logic [LANES-1:0]  exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [LANES-1:0] model_bits(input int b);
    logic [LANES-1:0] r;
    logic [WORD_W-1:0] w;
    for (int l = 0; l < LANES; l++) begin
      w    = model[l][b / WORD_W];
      r[l] = w[b % WORD_W];
    end
    return r;
  endfunction

  task automatic write_word(input int lane, input int addr, input logic [WORD_W-1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = SEL_W'(lane);
    wr_addr = ADDR_W'(addr);
    wr_data = d;
    model[lane][addr] = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // Start a pass, then check PRIME latency, every scored bit, and the FINISH/done tail.
  task automatic run_send(input string name, input int len_in, input bit loop_in,
                          input int n_bits, input bit do_stop);
    int eff;
    int vcnt;
    int idx;
    logic [LANES-1:0] e;
    eff  = (len_in > BUFFER_SIZE) ? BUFFER_SIZE : len_in;
    vcnt = 0;
    idx  = 0;
    exp_q.delete();
    for (int i = 0; i < n_bits; i++) exp_q.push_back(model_bits(i % eff));
    @(negedge clk);
    start  = 1'b1;
    length = LEN_W'(len_in);
    loop   = loop_in;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_prime: valid=%b busy=%b done=%b required valid=0 busy=1 done=0",
               name, tx_valid, busy, done);
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (tx_valid === 1'b1) vcnt++;
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        n_fail++;
        $display("FAIL %s_bit%0d: valid=%b data=%h required valid=1 data=%h",
                 name, idx, tx_valid, tx_data, e);
      end
      idx++;
    end
    n_checks++;
    if (vcnt !== n_bits) begin
      n_fail++;
      $display("FAIL %s_count: valid cycles=%0d required %0d", name, vcnt, n_bits);
    end
    if (do_stop) stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== '0 || done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_finish: valid=%b data=%h done=%b busy=%b required 0/0/1/1",
               name, tx_valid, tx_data, done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: valid=%b done=%b busy=%b required 0/0/0",
               name, tx_valid, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
    length = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_data !== '0 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: data=%h valid=%b busy=%b done=%b required all 0",
               tx_data, tx_valid, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int l = 0; l < LANES; l++)
      for (int w = 0; w < WORDS; w++) write_word(l, w, $urandom());
  endtask

  task automatic test_basic();
    write_word(0, 0, 32'hA5A5_A5A5);
    for (int l = 1; l < LANES; l++) write_word(l, 0, 32'h0);
    run_send("basic", 8, 1'b0, 8, 1'b0);
  endtask

  task automatic test_multiword();
    for (int l = 0; l < LANES; l++)
      for (int w = 0; w < 4; w++)
        write_word(l, w, 32'h8C3A_5E71 ^ (32'(l) << 24) ^ (32'(w) * 32'h0111_1111));
    run_send("multi", 128, 1'b0, 128, 1'b0);
  endtask

  task automatic test_loop();
`ifdef DATA_SEND_BUFFER_LOOP_EN
    run_send("loop", 5, 1'b1, 23, 1'b1);
`else
    run_send("loop_off", 5, 1'b1, 5, 1'b0);
`endif
  endtask

  task automatic test_ignored_requests();
    @(negedge clk);
    start = 1'b1; length = LEN_W'(0);
    @(negedge clk);
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    start = 1'b1; stop = 1'b1; length = LEN_W'(5);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL ignored_c%0d: busy=%b valid=%b done=%b required 0/0/0",
                 k, busy, tx_valid, done);
      end
    end
  endtask

  task automatic test_clamp();
    run_send("clamp", 5000, 1'b0, BUFFER_SIZE, 1'b0);
  endtask

  task automatic test_reset_mid_send();
    logic [LANES-1:0] e;
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back(model_bits(i));
    @(negedge clk);
    start = 1'b1; length = LEN_W'(100); loop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        n_fail++;
        $display("FAIL rstmid_bit%0d: valid=%b data=%h required valid=1 data=%h",
                 i, tx_valid, tx_data, e);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (tx_data !== '0 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: data=%h valid=%b busy=%b done=%b required all 0",
               tx_data, tx_valid, busy, done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nodone: done=%b busy=%b required 0/0", done, busy);
    end
    run_send("after_rst", 100, 1'b0, 100, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_multiword();
    test_loop();
    test_ignored_requests();
    test_clamp();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
